apb_slave_mem: RTL and testbench
================================

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 The block SHALL have a parameter data_size, default 8, giving the width of pwdata, prdata and each storage word.
REQ-002 The block SHALL have a parameter address_size, default 5, giving the width of paddr.
REQ-003 The block SHALL have a parameter mem_depth, default 24, giving the number of implemented words, 1..2^address_size.
REQ-004 The block SHALL have a parameter wait_states, default 2, giving the wait cycles inserted per transfer, 0..15.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port psel, input, 1 bit: slave select from the APB bridge.
REQ-008 The block SHALL have port penable, input, 1 bit: access-phase indicator.
REQ-009 The block SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port paddr, input, address_size bits: word address.
REQ-011 The block SHALL have port pwdata, input, data_size bits: write data.
REQ-012 The block SHALL have port prdata, output, data_size bits: read data, registered.
REQ-013 The block SHALL have port pready, output, 1 bit: transfer-complete indicator.
REQ-014 The block SHALL have port pslverr, output, 1 bit: error response, valid only while pready=1.

Function
REQ-015 The FSM SHALL have two states, IDLE and ACCESS, plus a 4-bit wait counter cnt.
REQ-016 In IDLE, psel=1 and penable=0 (setup cycle) SHALL load cnt=wait_states, capture the address-error flag (paddr >= mem_depth) and go to ACCESS.
REQ-017 For a read at that setup edge, prdata SHALL load mem[paddr], or 0 on an address error; otherwise prdata SHALL hold its value.
REQ-018 In ACCESS, pready SHALL equal (cnt==0), combinationally from registered state; cnt SHALL decrement each cycle while nonzero.
REQ-019 pready=1 SHALL appear in the (wait_states+1)-th cycle of the access phase; with wait_states=0 it appears in the first access cycle.
REQ-020 On an ACCESS edge with psel=1, penable=1 and pready=1, a write SHALL commit pwdata to mem[paddr] unless the error flag is set, and the FSM SHALL return to IDLE.
REQ-021 pslverr SHALL equal the error flag while pready=1, else 0; an erroring write SHALL leave memory unchanged.
REQ-022 If psel falls while in ACCESS before completion, the block SHALL abort to IDLE with no write and pready=0.
REQ-023 Back-to-back transfers (completion followed immediately by a setup cycle) SHALL be accepted with no idle gap required.
REQ-024 pready and pslverr SHALL be 0 in IDLE; psel=1 with penable=1 while in IDLE SHALL be ignored.

Reset
REQ-025 Reset SHALL force state=IDLE, cnt=0, prdata=0, pready=0, pslverr=0 and clear every memory word to 0, asynchronously.
REQ-026 Reset asserted mid-transfer SHALL discard the transfer; no write commits on that cycle.

Structure
REQ-027 State encodings (IDLE, ACCESS) and the default width constants SHALL live in the shared package apb_pkg.
REQ-028 Storage SHALL be a sub-module apb_slave_regfile: one synchronous write port, one read port, async clear.

Verification
REQ-029 Write 0xA5 to addr 3, then read addr 3 (wait_states=2) -> pready high in the 3rd access cycle each time; prdata=0xA5; pslverr=0.
REQ-030 Write to addr 30 (mem_depth=24) -> pslverr=1 with pready; a subsequent read of addr 30 returns prdata=0 with pslverr=1; memory unchanged.
REQ-031 wait_states=0, back-to-back writes to addrs 0,1,2 -> each completes in 2 cycles (setup + access); readback matches.
REQ-032 psel dropped in the 2nd access cycle of a write of 0x3C to addr 5 -> FSM in IDLE, mem[5] unchanged, pready never asserted.
REQ-033 reset pulsed in the middle of a write access -> all outputs 0 immediately, mem[addr]=0, and the next transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared constants for the APB slave memory: default widths and FSM state encodings.
package apb_pkg;
  localparam int DATA_SIZE   = 8;
  localparam int ADDR_SIZE   = 5;
  localparam int MEM_DEPTH   = 24;
  localparam int WAIT_STATES = 2;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;
endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the bridge (master) and the slave memory.
interface apb_slave_mem_if #(
  parameter int data_size    = apb_pkg::DATA_SIZE,
  parameter int address_size = apb_pkg::ADDR_SIZE
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [address_size-1:0] paddr;
  logic [data_size-1:0]    pwdata;
  logic [data_size-1:0]    prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_slave_regfile.sv
// Word storage: one synchronous write port, one combinational read port, async clear.
module apb_slave_regfile #(
  parameter int data_size    = 8,
  parameter int address_size = 5,
  parameter int mem_depth    = 24
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we,
  input  logic [address_size-1:0] waddr,
  input  logic [data_size-1:0]    wdata,
  input  logic [address_size-1:0] raddr,
  output logic [data_size-1:0]    rdata
);
  logic [data_size-1:0] mem_q [mem_depth];
  logic [data_size-1:0] mem_d [mem_depth];

  always_comb begin
    mem_d = mem_q;
    if (we && (32'(waddr) < mem_depth)) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  // Unimplemented addresses read as zero.
  assign rdata = (32'(raddr) < mem_depth) ? mem_q[raddr] : '0;
endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with a small word memory, programmable wait states and an address-range error.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int data_size    = DATA_SIZE,
  parameter int address_size = ADDR_SIZE,
  parameter int mem_depth    = MEM_DEPTH,
  parameter int wait_states  = WAIT_STATES
) (
  input  logic             clock,
  input  logic             reset,
  apb_slave_mem_if.slave   bus
);
  localparam logic [3:0] WS = 4'(wait_states);

  logic [0:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [data_size-1:0] prdata_q, prdata_d;
  logic [data_size-1:0] rdata;
  logic                 we, addr_err, pready;

  assign addr_err = (32'(bus.paddr) >= mem_depth);
  assign pready   = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

  apb_slave_regfile #(
    .data_size(data_size), .address_size(address_size), .mem_depth(mem_depth)
  ) u_regfile (
    .clock(clock), .reset(reset), .we(we),
    .waddr(bus.paddr), .wdata(bus.pwdata),
    .raddr(bus.paddr), .rdata(rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only a genuine setup cycle starts a transfer; psel+penable here is ignored.
        if (bus.psel && !bus.penable) begin
          state_d = ST_ACCESS;
          cnt_d   = WS;
          err_d   = addr_err;
          if (!bus.pwrite) prdata_d = addr_err ? '0 : rdata;
        end
      end
      default: begin
        if (!bus.psel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          if (bus.penable && pready) begin
            we      = bus.pwrite && !err_q;
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready;
  assign bus.pslverr = pready && err_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: two DUTs (2 and 0 wait states) driven from one APB master, psel steered by dsel.
module tb_apb_slave_mem;
  import apb_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       psel, penable, pwrite, dsel;
  logic [4:0] paddr;
  logic [7:0] pwdata;

  always #5 clock = ~clock;

  apb_slave_mem_if #(.data_size(8), .address_size(5)) bus0();
  apb_slave_mem_if #(.data_size(8), .address_size(5)) bus1();

  assign bus0.psel    = psel & ~dsel;
  assign bus1.psel    = psel &  dsel;
  assign bus0.penable = penable;
  assign bus1.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus1.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus1.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus1.pwdata  = pwdata;

  apb_slave_mem #(.data_size(8), .address_size(5), .mem_depth(24), .wait_states(2))
    dut0 (.clock(clock), .reset(reset), .bus(bus0));
  apb_slave_mem #(.data_size(8), .address_size(5), .mem_depth(24), .wait_states(0))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));

  wire       pready_m  = dsel ? bus1.pready  : bus0.pready;
  wire       pslverr_m = dsel ? bus1.pslverr : bus0.pslverr;
  wire [7:0] prdata_m  = dsel ? bus1.prdata  : bus0.prdata;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Setup + access phase; returns data/err sampled in the pready cycle and the access-cycle count.
  task automatic xfer(input logic wr, input logic [4:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic err, output int cyc);
    @(posedge clock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clock); #1;
    penable = 1'b1;
    cyc = 1;
    while (!pready_m && cyc < 32) begin
      @(posedge clock); #1;
      cyc++;
    end
    rd  = prdata_m;
    err = pslverr_m;
  endtask

  task automatic idle();
    @(posedge clock); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [7:0] rd;
  logic       err;
  int         cyc;

  initial begin
    reset = 1'b1; dsel = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pready",  32'(bus0.pready),  0);
    chk("rst_pslverr", 32'(bus0.pslverr), 0);
    chk("rst_prdata",  32'(bus0.prdata),  0);
    chk("rst_state",   32'(dut0.state_q), 32'(ST_IDLE));
    reset = 1'b0;

    // write/read with two wait states
    xfer(1'b1, 5'd3, 8'hA5, rd, err, cyc);
    chk("wr3_cyc", cyc, 3);  chk("wr3_err", 32'(err), 0);
    xfer(1'b0, 5'd3, 8'h00, rd, err, cyc);
    chk("rd3_cyc", cyc, 3);  chk("rd3_data", 32'(rd), 32'hA5); chk("rd3_err", 32'(err), 0);
    xfer(1'b1, 5'd23, 8'h5A, rd, err, cyc);
    chk("wr23_err", 32'(err), 0);
    xfer(1'b0, 5'd23, 8'h00, rd, err, cyc);
    chk("rd23_data", 32'(rd), 32'h5A); chk("rd23_err", 32'(err), 0);

    // out-of-range accesses
    xfer(1'b1, 5'd30, 8'hFF, rd, err, cyc);
    chk("wr30_cyc", cyc, 3); chk("wr30_err", 32'(err), 1);
    xfer(1'b0, 5'd30, 8'h00, rd, err, cyc);
    chk("rd30_data", 32'(rd), 0); chk("rd30_err", 32'(err), 1);
    xfer(1'b0, 5'd6, 8'h00, rd, err, cyc);
    chk("rd6_alias", 32'(rd), 0);
    xfer(1'b0, 5'd3, 8'h00, rd, err, cyc);
    chk("rd3_keep", 32'(rd), 32'hA5);
    xfer(1'b0, 5'd24, 8'h00, rd, err, cyc);
    chk("rd24_err", 32'(err), 1); chk("rd24_data", 32'(rd), 0);
    idle();

    // psel+penable without a setup cycle is ignored
    @(posedge clock); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 5'd4; pwdata = 8'h77;
    repeat (2) begin
      @(posedge clock); #1;
      chk("nosetup_pready", 32'(bus0.pready), 0);
      chk("nosetup_state",  32'(dut0.state_q), 32'(ST_IDLE));
    end
    psel = 1'b0; penable = 1'b0;

    // abort: psel dropped in the 2nd access cycle
    @(posedge clock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'd5; pwdata = 8'h3C;
    @(posedge clock); #1;
    penable = 1'b1;
    chk("abort_acc1_pready", 32'(bus0.pready), 0);
    @(posedge clock); #1;
    chk("abort_acc2_pready", 32'(bus0.pready), 0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clock); #1;
    chk("abort_state",  32'(dut0.state_q), 32'(ST_IDLE));
    chk("abort_pready", 32'(bus0.pready), 0);
    xfer(1'b0, 5'd5, 8'h00, rd, err, cyc);
    chk("abort_rd5_cyc", cyc, 3); chk("abort_rd5_data", 32'(rd), 0);
    xfer(1'b0, 5'd4, 8'h00, rd, err, cyc);
    chk("nosetup_rd4_data", 32'(rd), 0);

    // reset in the completing cycle of a write
    xfer(1'b0, 5'd3, 8'h00, rd, err, cyc);
    chk("prerst_rd3", 32'(rd), 32'hA5);
    xfer(1'b1, 5'd7, 8'h5A, rd, err, cyc);
    chk("prerst_wr7_cyc", cyc, 3);
    #2 reset = 1'b1;
    #1;
    chk("midrst_pready",  32'(bus0.pready),  0);
    chk("midrst_pslverr", 32'(bus0.pslverr), 0);
    chk("midrst_prdata",  32'(bus0.prdata),  0);
    chk("midrst_state",   32'(dut0.state_q), 32'(ST_IDLE));
    @(posedge clock); #1;
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer(1'b0, 5'd7, 8'h00, rd, err, cyc);
    chk("postrst_rd7_cyc", cyc, 3); chk("postrst_rd7", 32'(rd), 0);
    xfer(1'b0, 5'd3, 8'h00, rd, err, cyc);
    chk("postrst_rd3", 32'(rd), 0);
    xfer(1'b1, 5'd7, 8'hC3, rd, err, cyc);
    chk("postrst_wr7_cyc", cyc, 3);
    xfer(1'b0, 5'd7, 8'h00, rd, err, cyc);
    chk("postrst_rd7_new", 32'(rd), 32'hC3);
    idle();

    // zero wait states, back-to-back
    dsel = 1'b1;
    xfer(1'b1, 5'd0, 8'h11, rd, err, cyc); chk("ws0_wr0_cyc", cyc, 1);
    xfer(1'b1, 5'd1, 8'h22, rd, err, cyc); chk("ws0_wr1_cyc", cyc, 1);
    xfer(1'b1, 5'd2, 8'h33, rd, err, cyc); chk("ws0_wr2_cyc", cyc, 1);
    xfer(1'b0, 5'd0, 8'h00, rd, err, cyc); chk("ws0_rd0", 32'(rd), 32'h11); chk("ws0_rd0_cyc", cyc, 1);
    xfer(1'b0, 5'd1, 8'h00, rd, err, cyc); chk("ws0_rd1", 32'(rd), 32'h22);
    xfer(1'b0, 5'd2, 8'h00, rd, err, cyc); chk("ws0_rd2", 32'(rd), 32'h33);
    xfer(1'b0, 5'd31, 8'h00, rd, err, cyc);
    chk("ws0_rd31_err", 32'(err), 1); chk("ws0_rd31_data", 32'(rd), 0);
    idle();
    @(posedge clock); #1;
    chk("ws0_end_pready", 32'(bus1.pready), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
